multicyc_fsm_ctrl: RTL and testbench

Main sequencing FSM for the multicycle MIPS core. It drives the shared ALU, single memory port, IR/PC/regfile write enables and datapath muxes state by state, from the IR opcode/funct, the ALU zero flag and a memory ready handshake. It also counts retired instructions and halts on an illegal instruction or a memory timeout. Its ALU-op encoding matches the core's ALU control block: 00 add, 01 sub, 10 by funct, 11 by opcode.

---
 rtl/multicyc_fsm_ctrl.sv | 277 +++++++++++++++++++++++++++
 tb/tb_multicyc_fsm_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicyc_fsm_ctrl.sv
// -----------------------------------------------------------------------------
// multicyc_fsm_ctrl
// Main sequencing FSM of the multicycle MIPS core. It steers the shared ALU,
// the single memory port, the IR/PC/regfile write enables and the datapath
// muxes state by state. It also counts retired instructions and halts on an
// illegal instruction or on a memory access that stays not-ready too long.
//
// Parameters
//   MEM_TIMEOUT : consecutive not-ready cycles in a memory state before HALT
//                 (0 disables the timeout)
//   CNT_W       : width of the retired-instruction counter
//
// Ports
//   iClk, iRst            : clock, asynchronous active-high reset
//   iOpCode, iFunct       : IR[31:26], IR[5:0]
//   iAluZero              : ALU zero flag (same cycle)
//   iMemReady             : memory completes the current access this cycle
//   oMemRead, oMemWrite   : memory strobes
//   oIorD                 : memory address select (0 PC, 1 ALUOut)
//   oIRWrite, oPCWrite    : IR / PC load enables
//   oPCSrc                : 00 ALU, 01 ALUOut, 10 jump target, 11 rs
//   oALUSrcA, oALUSrcB    : ALU operand selects
//   oALUOp                : 00 add, 01 sub, 10 by funct, 11 by opcode
//   oRegWrite, oRegDst,
//   oMemtoReg             : regfile write enable and selects
//   oState                : current state code
//   oRetired              : retired instruction count
//   oIllegal, oTimeout    : sticky halt causes
// -----------------------------------------------------------------------------
module multicyc_fsm_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [5:0]       iOpCode,
  input  logic [5:0]       iFunct,
  input  logic             iAluZero,
  input  logic             iMemReady,
  output logic             oMemRead,
  output logic             oMemWrite,
  output logic             oIorD,
  output logic             oIRWrite,
  output logic             oPCWrite,
  output logic [1:0]       oPCSrc,
  output logic             oALUSrcA,
  output logic [1:0]       oALUSrcB,
  output logic [1:0]       oALUOp,
  output logic             oRegWrite,
  output logic [1:0]       oRegDst,
  output logic [1:0]       oMemtoReg,
  output logic [3:0]       oState,
  output logic [CNT_W-1:0] oRetired,
  output logic             oIllegal,
  output logic             oTimeout
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_WB_MEM   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_WB_R     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_WB_I     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JR       = 4'd12,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ADDIU= 6'h09;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_SLTIU= 6'h0B;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  // The wait counter only has to reach MEM_TIMEOUT-1; the timeout fires on
  // the not-ready cycle observed while it holds that value.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

  state_t            r_state;
  state_t            w_next;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_retired;
  logic              r_illegal;
  logic              r_timeout;

  logic       w_in_mem;
  logic       w_stall;
  logic       w_timeout_hit;
  logic       w_funct_legal;
  logic       w_mem_read, w_mem_write, w_iord, w_irwrite, w_pcwrite;
  logic       w_alusrca, w_regwrite;
  logic [1:0] w_pcsrc, w_alusrcb, w_aluop, w_regdst, w_memtoreg;

  assign w_in_mem      = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                         (r_state == S_MEM_WR);
  assign w_stall       = w_in_mem && !iMemReady;
  assign w_timeout_hit = (MEM_TIMEOUT > 0) && w_stall && (r_wait == WAIT_LAST);
  assign w_funct_legal = iFunct inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06,
                                        6'h07, [6'h20:6'h27], 6'h2A};

  always_comb begin
    w_next      = r_state;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_iord      = 1'b0;
    w_irwrite   = 1'b0;
    w_pcwrite   = 1'b0;
    w_pcsrc     = 2'b00;
    w_alusrca   = 1'b0;
    w_alusrcb   = 2'b00;
    w_aluop     = 2'b00;
    w_regwrite  = 1'b0;
    w_regdst    = 2'b00;
    w_memtoreg  = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        w_alusrcb  = 2'b01;
        w_irwrite  = iMemReady;
        w_pcwrite  = iMemReady;
        if (iMemReady)          w_next = S_DECODE;
        else if (w_timeout_hit) w_next = S_HALT;
      end
      S_DECODE: begin
        // Branch target computed speculatively into ALUOut.
        w_alusrcb = 2'b11;
        case (iOpCode)
          OP_LW, OP_SW:   w_next = S_MEM_ADDR;
          OP_R: begin
            if (iFunct == FN_JR || iFunct == FN_JALR) w_next = S_JR;
            else if (w_funct_legal)                   w_next = S_EXEC_R;
            else                                      w_next = S_HALT;
          end
          OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
          OP_ANDI, OP_ORI, OP_LUI: w_next = S_EXEC_I;
          OP_BEQ, OP_BNE:  w_next = S_BRANCH;
          OP_J, OP_JAL:    w_next = S_JUMP;
          default:         w_next = S_HALT;
        endcase
      end
      S_MEM_ADDR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = (iOpCode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
        if (iMemReady)          w_next = S_WB_MEM;
        else if (w_timeout_hit) w_next = S_HALT;
      end
      S_WB_MEM: begin
        w_regwrite = 1'b1;
        w_memtoreg = 2'b01;
        w_next     = S_FETCH;
      end
      S_MEM_WR: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
        if (iMemReady)          w_next = S_FETCH;
        else if (w_timeout_hit) w_next = S_HALT;
      end
      S_EXEC_R: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
        w_next    = S_WB_R;
      end
      S_WB_R: begin
        w_regwrite = 1'b1;
        w_regdst   = 2'b01;
        w_next     = S_FETCH;
      end
      S_EXEC_I: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_aluop   = 2'b11;
        w_next    = S_WB_I;
      end
      S_WB_I: begin
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b01;
        w_pcsrc   = 2'b01;
        w_pcwrite = (iOpCode == OP_BNE) ? !iAluZero : iAluZero;
        w_next    = S_FETCH;
      end
      S_JUMP: begin
        w_pcwrite = 1'b1;
        w_pcsrc   = 2'b10;
        if (iOpCode == OP_JAL) begin
          // Link value is PC, which already holds PC+4 here.
          w_regwrite = 1'b1;
          w_regdst   = 2'b10;
          w_memtoreg = 2'b10;
        end
        w_next = S_FETCH;
      end
      S_JR: begin
        w_pcwrite = 1'b1;
        w_pcsrc   = 2'b11;
        if (iFunct == FN_JALR) begin
          w_regwrite = 1'b1;
          w_regdst   = 2'b01;
          w_memtoreg = 2'b10;
        end
        w_next = S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_HALT;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_retired <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      // Any transition (including a ready) clears the wait count, so entry
      // into a memory state always starts from zero.
      if (w_stall && !w_timeout_hit) r_wait <= r_wait + WAIT_W'(1);
      else                           r_wait <= '0;
      if (r_state != S_FETCH && w_next == S_FETCH)
        r_retired <= r_retired + CNT_W'(1);
      if (r_state == S_DECODE && w_next == S_HALT)
        r_illegal <= 1'b1;
      if (w_timeout_hit)
        r_timeout <= 1'b1;
    end
  end

  // Strobes are suppressed for the whole reset pulse; mux selects simply
  // follow FETCH because the state register is already forced there.
  assign oMemRead  = w_mem_read  & ~iRst;
  assign oMemWrite = w_mem_write & ~iRst;
  assign oIRWrite  = w_irwrite   & ~iRst;
  assign oPCWrite  = w_pcwrite   & ~iRst;
  assign oRegWrite = w_regwrite  & ~iRst;
  assign oIorD     = w_iord;
  assign oPCSrc    = w_pcsrc;
  assign oALUSrcA  = w_alusrca;
  assign oALUSrcB  = w_alusrcb;
  assign oALUOp    = w_aluop;
  assign oRegDst   = w_regdst;
  assign oMemtoReg = w_memtoreg;
  assign oState    = r_state;
  assign oRetired  = r_retired;
  assign oIllegal  = r_illegal;
  assign oTimeout  = r_timeout;

endmodule

// File: tb/tb_multicyc_fsm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicyc_fsm_ctrl
// Directed scenarios followed by randomized instruction streams. The reference
// model tracks each instruction as a list of states to visit after DECODE,
// with memory states held while not ready, and derives the expected control
// word per state from the instruction encoding table.
// -----------------------------------------------------------------------------
module tb_multicyc_fsm_ctrl;

  localparam int TO    = 16;
  localparam int CNT_W = 32;

  logic             iClk = 1'b0;
  logic             iRst = 1'b1;
  logic [5:0]       iOpCode = '0;
  logic [5:0]       iFunct = '0;
  logic             iAluZero = 1'b0;
  logic             iMemReady = 1'b0;
  logic             oMemRead, oMemWrite, oIorD, oIRWrite, oPCWrite;
  logic [1:0]       oPCSrc;
  logic             oALUSrcA;
  logic [1:0]       oALUSrcB, oALUOp;
  logic             oRegWrite;
  logic [1:0]       oRegDst, oMemtoReg;
  logic [3:0]       oState;
  logic [CNT_W-1:0] oRetired;
  logic             oIllegal, oTimeout;

  multicyc_fsm_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .iClk(iClk), .iRst(iRst), .iOpCode(iOpCode), .iFunct(iFunct),
    .iAluZero(iAluZero), .iMemReady(iMemReady),
    .oMemRead(oMemRead), .oMemWrite(oMemWrite), .oIorD(oIorD),
    .oIRWrite(oIRWrite), .oPCWrite(oPCWrite), .oPCSrc(oPCSrc),
    .oALUSrcA(oALUSrcA), .oALUSrcB(oALUSrcB), .oALUOp(oALUOp),
    .oRegWrite(oRegWrite), .oRegDst(oRegDst), .oMemtoReg(oMemtoReg),
    .oState(oState), .oRetired(oRetired), .oIllegal(oIllegal),
    .oTimeout(oTimeout)
  );

  always #5 iClk = ~iClk;

  logic [16:0] dut_ctrl;
  assign dut_ctrl = {oMemRead, oMemWrite, oIorD, oIRWrite, oPCWrite, oPCSrc,
                     oALUSrcA, oALUSrcB, oALUOp, oRegWrite, oRegDst, oMemtoReg};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_state;
  int          m_wait;
  logic [31:0] m_ret;
  logic        m_ill, m_to;
  int          plan[$];
  logic [5:0]  cur_op = '0;
  logic [5:0]  cur_funct = '0;

  function automatic bit funct_ok(input logic [5:0] f);
    return f inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                     6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                     6'h2A};
  endfunction

  // States visited after DECODE for one instruction (15 = illegal halt).
  task automatic build_plan(input logic [5:0] op, input logic [5:0] fn);
    plan = {};
    if (op == 6'h23)                              plan = {2, 3, 4};
    else if (op == 6'h2B)                         plan = {2, 5};
    else if (op == 6'h00 && (fn == 6'h08 || fn == 6'h09)) plan = {12};
    else if (op == 6'h00 && funct_ok(fn))         plan = {6, 7};
    else if (op inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F})
                                                  plan = {8, 9};
    else if (op == 6'h04 || op == 6'h05)          plan = {10};
    else if (op == 6'h02 || op == 6'h03)          plan = {11};
    else                                          plan = {15};
  endtask

  function automatic logic [16:0] exp_ctrl(input int s, input logic [5:0] op,
      input logic [5:0] fn, input logic rdy, input logic zr, input logic rst);
    logic mr, mw, iord, irw, pcw, srca, rw;
    logic [1:0] pcsrc, srcb, aluop, regdst, m2r;
    {mr, mw, iord, irw, pcw, srca, rw} = '0;
    {pcsrc, srcb, aluop, regdst, m2r} = '0;
    case (s)
      0:  begin mr = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
      1:  srcb = 2'b11;
      2:  begin srca = 1; srcb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 2'b01; end
      5:  begin mw = 1; iord = 1; end
      6:  begin srca = 1; aluop = 2'b10; end
      7:  begin rw = 1; regdst = 2'b01; end
      8:  begin srca = 1; srcb = 2'b10; aluop = 2'b11; end
      9:  rw = 1;
      10: begin srca = 1; aluop = 2'b01; pcsrc = 2'b01;
                pcw = (op == 6'h04) ? zr : ~zr; end
      11: begin pcw = 1; pcsrc = 2'b10;
                if (op == 6'h03) begin rw = 1; regdst = 2'b10; m2r = 2'b10; end
          end
      12: begin pcw = 1; pcsrc = 2'b11;
                if (fn == 6'h09) begin rw = 1; regdst = 2'b01; m2r = 2'b10; end
          end
      default: ;
    endcase
    if (rst) begin mr = 0; mw = 0; irw = 0; pcw = 0; rw = 0; end
    return {mr, mw, iord, irw, pcw, pcsrc, srca, srcb, aluop, rw, regdst, m2r};
  endfunction

  task automatic model_reset();
    m_state = 0; m_wait = 0; m_ret = '0; m_ill = 0; m_to = 0; plan = {};
  endtask

  task automatic model_advance(input logic rdy);
    if (m_state == 15) return;
    if ((m_state == 0 || m_state == 3 || m_state == 5) && !rdy) begin
      m_wait++;
      if (TO > 0 && m_wait >= TO) begin m_state = 15; m_to = 1; end
      return;
    end
    m_wait = 0;
    if (m_state == 0) m_state = 1;
    else if (m_state == 1) begin
      build_plan(cur_op, cur_funct);
      m_state = plan.pop_front();
      if (m_state == 15) m_ill = 1;
    end else if (plan.size() == 0) begin
      m_state = 0; m_ret++;
    end else m_state = plan.pop_front();
  endtask

  // One clock cycle: drive, check outputs against the model, advance model.
  task automatic step(input logic rdy, input logic zr);
    @(negedge iClk);
    iMemReady = rdy; iAluZero = zr; iOpCode = cur_op; iFunct = cur_funct;
    #1;
    check_val("ctrl", dut_ctrl, exp_ctrl(m_state, cur_op, cur_funct, rdy, zr, 1'b0));
    check_val("state", oState, m_state);
    check_val("retired", oRetired, m_ret);
    check_val("illegal", oIllegal, m_ill);
    check_val("timeout", oTimeout, m_to);
    model_advance(rdy);
  endtask

  task automatic do_reset();
    @(negedge iClk);
    iRst = 1'b1; iMemReady = 1'b1;
    #1;
    model_reset();
    check_val("rst_ctrl", dut_ctrl, exp_ctrl(0, cur_op, cur_funct, 1'b1, iAluZero, 1'b1));
    check_val("rst_state", oState, 0);
    check_val("rst_retired", oRetired, 0);
    check_val("rst_flags", {oIllegal, oTimeout}, 0);
    @(posedge iClk);
    #1;
    check_val("rst_hold_state", oState, 0);
    iRst = 1'b0;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic zr, input int cycles);
    cur_op = op; cur_funct = fn;
    for (int k = 0; k < cycles; k++) step(1'b1, zr);
  endtask

  logic [5:0] legal_ops[15] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                                6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F,
                                6'h23, 6'h2B, 6'h00};
  logic [5:0] bad_ops[5]   = '{6'h01, 6'h06, 6'h07, 6'h10, 6'h3F};
  logic [5:0] r_functs[17] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                               6'h08, 6'h09, 6'h20, 6'h21, 6'h22, 6'h23,
                               6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};

  initial begin
    int stall;
    int halt_cnt;
    logic rdy;
    model_reset();
    do_reset();

    // ADDU: 0,1,6,7 then back in FETCH with one retired
    run_instr(6'h00, 6'h21, 1'b0, 4);
    @(posedge iClk); #1;
    check_val("addu_retired", oRetired, 1);
    check_val("addu_back_fetch", oState, 0);

    // LW with three not-ready cycles in MEM_RD
    cur_op = 6'h23; cur_funct = 6'h00;
    step(1, 0); step(1, 0); step(1, 0);
    step(0, 0); step(0, 0); step(0, 0); step(1, 0); step(1, 0);

    // Branches with both zero polarities
    run_instr(6'h04, 6'h00, 1'b1, 3);
    run_instr(6'h04, 6'h00, 1'b0, 3);
    run_instr(6'h05, 6'h00, 1'b0, 3);
    run_instr(6'h05, 6'h00, 1'b1, 3);

    // Jumps and register jumps
    run_instr(6'h03, 6'h00, 1'b0, 3);
    run_instr(6'h02, 6'h00, 1'b0, 3);
    run_instr(6'h00, 6'h09, 1'b0, 3);
    run_instr(6'h00, 6'h08, 1'b0, 3);
    run_instr(6'h2B, 6'h00, 1'b0, 4);
    run_instr(6'h0C, 6'h00, 1'b0, 4);

    // Ready on the 16th not-ready-eligible cycle wins
    cur_op = 6'h0D;
    for (int k = 0; k < TO - 1; k++) step(0, 0);
    step(1, 0);
    run_instr(6'h0D, 6'h00, 1'b0, 3);

    // Fetch timeout
    for (int k = 0; k < TO; k++) step(0, 0);
    for (int k = 0; k < 4; k++) step(1, 0);
    check_val("to_halt_state", oState, 15);
    do_reset();

    // Timeout inside MEM_WR
    cur_op = 6'h2B;
    step(1, 0); step(1, 0); step(1, 0);
    for (int k = 0; k < TO + 2; k++) step(0, 0);
    do_reset();

    // Illegal opcode halts with strobes quiet
    run_instr(6'h3F, 6'h00, 1'b0, 2);
    for (int k = 0; k < 20; k++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check_val("ill_flag", oIllegal, 1);
    do_reset();

    // Illegal R funct, then reset in the middle of an LW
    run_instr(6'h00, 6'h01, 1'b0, 3);
    do_reset();
    cur_op = 6'h23;
    step(1, 0); step(1, 0); step(1, 0); step(0, 0);
    do_reset();

    // Randomized instruction streams
    stall = 0;
    halt_cnt = 0;
    for (int i = 0; i < 2500; i++) begin
      if (m_state == 0) begin
        if ($urandom_range(0, 19) == 0)
          cur_op = bad_ops[$urandom_range(0, 4)];
        else
          cur_op = legal_ops[$urandom_range(0, 14)];
        if ($urandom_range(0, 15) == 0) cur_funct = 6'($urandom_range(0, 63));
        else cur_funct = r_functs[$urandom_range(0, 16)];
      end
      if (stall > 0) begin
        rdy = 1'b0; stall--;
      end else begin
        if ($urandom_range(0, 49) == 0) stall = $urandom_range(13, 18);
        rdy = ($urandom_range(0, 3) != 0);
      end
      step(rdy, 1'($urandom_range(0, 1)));
      if (m_state == 15) begin
        halt_cnt++;
        if (halt_cnt > 3) begin
          do_reset();
          halt_cnt = 0;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
